// File: rtl/inv_keyexpansion.sv
// AES-128 inverse key schedule: walks forward to round key 10, then emits
// round keys 10..0 one per valid/ready handshake from a single working register.
module inv_keyexpansion #(
    parameter int unsigned K = 128
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [K-1:0] key,
    output logic         busy,
    output logic [127:0] roundKey,
    output logic [3:0]   round,
    output logic         rkValid,
    input  logic         rkReady,
    output logic         done
);

    if (K != 128) begin : g_bad_k
        $error("inv_keyexpansion: only K=128 is supported");
    end

    localparam logic [3:0] LAST_FWD = 4'd9;
    localparam logic [7:0] RCON_FIRST = 8'h01;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        REV  = 2'd2
    } state_t;

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] inv_xtime(input logic [7:0] x);
        return x[0] ? (((x ^ 8'h1b) >> 1) | 8'h80) : (x >> 1);
    endfunction

    state_t       state;
    state_t       state_next;
    logic [7:0]   rcon;
    logic [7:0]   rcon_next;
    logic [127:0] rk_next;
    logic [3:0]   round_next;
    logic         valid_next;
    logic         done_next;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  p1, p2, p3;
    logic [31:0]  sub_in;
    logic [31:0]  sub_out;
    logic [31:0]  t, n0, n1, n2, n3, p0;
    logic [127:0] fwd_key;
    logic [127:0] rev_key;

    // Shared SubWord: w3 feeds the forward step, p3 the reverse step
    always_comb begin
        {w0, w1, w2, w3} = roundKey;
        p3      = w3 ^ w2;
        p2      = w2 ^ w1;
        p1      = w1 ^ w0;
        sub_in  = (state == REV) ? p3 : w3;
        sub_out = sub_word(rot_word(sub_in));
        t       = sub_out ^ {rcon, 24'h0};
        n0      = w0 ^ t;
        n1      = w1 ^ n0;
        n2      = w2 ^ n1;
        n3      = w3 ^ n2;
        p0      = w0 ^ t;
        fwd_key = {n0, n1, n2, n3};
        rev_key = {p0, p1, p2, p3};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = FWD;
            FWD:     if (round == LAST_FWD) state_next = REV;
            REV:     if (rkReady && (round == 4'd0)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Next values of the registered outputs and the Rcon tracker
    always_comb begin
        rk_next    = roundKey;
        round_next = round;
        valid_next = rkValid;
        done_next  = 1'b0;
        rcon_next  = rcon;
        case (state)
            IDLE: begin
                if (start) begin
                    rk_next    = 128'(key);
                    round_next = 4'd0;
                    rcon_next  = RCON_FIRST;
                end
            end
            FWD: begin
                rk_next    = fwd_key;
                round_next = 4'(round + 4'd1);
                // Rcon stays at 36 so the first reverse step reuses it
                if (round == LAST_FWD) begin
                    valid_next = 1'b1;
                end else begin
                    rcon_next = xtime(rcon);
                end
            end
            REV: begin
                if (rkReady) begin
                    if (round != 4'd0) begin
                        rk_next    = rev_key;
                        round_next = 4'(round - 4'd1);
                        rcon_next  = inv_xtime(rcon);
                    end else begin
                        valid_next = 1'b0;
                        done_next  = 1'b1;
                    end
                end
            end
            default: begin
                valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            roundKey <= 128'h0;
            round    <= 4'd0;
            rkValid  <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
            rcon     <= 8'h00;
        end else begin
            roundKey <= rk_next;
            round    <= round_next;
            rkValid  <= valid_next;
            done     <= done_next;
            busy     <= (state_next != IDLE);
            rcon     <= rcon_next;
        end
    end

endmodule

// File: tb/tb_inv_keyexpansion.sv
// Randomized self-checking bench for inv_keyexpansion against an arithmetic
// AES-128 key-expansion model (S-box derived from GF(2^8) inverse + affine map).
module tb_inv_keyexpansion;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] SEQ_KEY  = 128'h000102030405060708090a0b0c0d0e0f;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [127:0] key;
    logic         busy;
    logic [127:0] roundKey;
    logic [3:0]   round;
    logic         rkValid;
    logic         rkReady;
    logic         done;

    int errors = 0;
    int checks = 0;

    logic [7:0]   sbox_m [256];
    logic [127:0] model_rk [11];
    logic [131:0] got_q [$];
    bit           bp_mode = 1'b0;
    int           done_cnt = 0;
    bit           prev_stall = 1'b0;
    bit           prev_done = 1'b0;
    logic [127:0] prev_key;
    logic [3:0]   prev_round;

    inv_keyexpansion #(.K(128)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .key      (key),
        .busy     (busy),
        .roundKey (roundKey),
        .round    (round),
        .rkValid  (rkValid),
        .rkReady  (rkReady),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d = {b, b} << n;
        return d[15:8];
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                      ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic build_model(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc = 8'h01;
        w[0] = k[127:96]; w[1] = k[95:64]; w[2] = k[63:32]; w[3] = k[31:0];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox_m[tmp[31:24]], sbox_m[tmp[23:16]], sbox_m[tmp[15:8]], sbox_m[tmp[7:0]]};
                tmp = tmp ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++)
            model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Consumer-side monitor: handshakes, hold-under-backpressure, done pulse width
    always @(negedge clk) begin
        if (!reset) begin
            prev_stall = 1'b0;
            prev_done  = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_key", roundKey, prev_key);
                check("hold_round", 128'(round), 128'(prev_round));
            end
            if (rkValid && rkReady) got_q.push_back({round, roundKey});
            if (done) begin
                done_cnt++;
                check("done_single", 128'(prev_done), 128'(0));
            end
            prev_done  = done;
            prev_stall = rkValid && !rkReady;
            prev_key   = roundKey;
            prev_round = round;
        end
    end

    initial begin
        rkReady = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rkReady = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic start_key(input logic [127:0] k);
        @(posedge clk);
        #1;
        start = 1'b1;
        key   = k;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic check_sched(input string tag);
        check({tag, "_count"}, 128'(got_q.size()), 128'(11));
        for (int i = 0; i < got_q.size() && i < 11; i++) begin
            check({tag, "_round"}, 128'(got_q[i][131:128]), 128'(10 - i));
            check({tag, "_key"}, got_q[i][127:0], model_rk[10-i]);
        end
    endtask

    task automatic run_to_done(input string tag, input bit chain, input logic [127:0] nk);
        int n = 0;
        while (!done && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!done) check({tag, "_done_timeout"}, 128'(0), 128'(1));
        check_sched(tag);
        if (chain && done) begin
            build_model(nk);
            got_q.delete();
            start = 1'b1;
            key   = nk;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b0;
        start = 1'b0;
        key   = '0;
        build_sbox();
        repeat (3) @(posedge clk);
        #1;
        check("rst_key", roundKey, 128'h0);
        check("rst_ctl", {busy, rkValid, done, round}, 128'(0));
        @(negedge clk);
        reset = 1'b1;

        // FIPS-197 vector with rkReady held high
        got_q.delete();
        done_cnt = 0;
        build_model(FIPS_KEY);
        start_key(FIPS_KEY);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rkValid && n < 40);
        check("fill_cycles", 128'(n - 1), 128'(10));
        check("busy_fill", 128'(busy), 128'(1));
        check("r10_round", 128'(round), 128'(10));
        check("r10_key", roundKey, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        @(negedge clk);
        check("r9_round", 128'(round), 128'(9));
        check("r9_key", roundKey, 128'hac7766f319fadc2128d12941575c006e);
        run_to_done("fips", 1'b0, '0);
        if (got_q.size() == 11) begin
            check("fips_r1", got_q[9][127:0], 128'ha0fafe1788542cb123a339392a6c7605);
            check("fips_r0", got_q[10][127:0], FIPS_KEY);
        end
        repeat (3) @(negedge clk);
        check("done_count", 128'(done_cnt), 128'(1));
        check("idle_ctl", {busy, rkValid, done}, 128'(0));
        check("retain_key", roundKey, FIPS_KEY);

        // Start while busy is ignored; then start in the done cycle
        got_q.delete();
        build_model(FIPS_KEY);
        start_key(FIPS_KEY);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        key   = SEQ_KEY;
        @(posedge clk);
        #1;
        start = 1'b0;
        run_to_done("busy_start", 1'b1, SEQ_KEY);
        run_to_done("b2b", 1'b0, '0);
        if (got_q.size() > 0)
            check("b2b_r10", got_q[0][127:0], 128'h13111d7fe3944a17f307a78b4d2b30c5);

        // Backpressure
        bp_mode = 1'b1;
        got_q.delete();
        build_model(FIPS_KEY);
        start_key(FIPS_KEY);
        run_to_done("bp", 1'b0, '0);

        // Asynchronous reset during the reverse walk
        start_key(SEQ_KEY);
        n = 0;
        while (!(rkValid && round == 4'd5) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reach_r5", 128'(rkValid && round == 4'd5), 128'(1));
        #2;
        reset = 1'b0;
        #1;
        check("async_key", roundKey, 128'h0);
        check("async_ctl", {busy, rkValid, done, round}, 128'(0));
        repeat (2) @(negedge clk);
        reset = 1'b1;
        bp_mode = 1'b0;

        // Random keys, a quarter of them under backpressure
        for (int i = 0; i < 1000; i++) begin
            logic [127:0] k;
            k = {$urandom, $urandom, $urandom, $urandom};
            bp_mode = (i % 4 == 1);
            got_q.delete();
            build_model(k);
            start_key(k);
            run_to_done("rand", 1'b0, '0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inv_keyexpansion.md
Name: inv_keyexpansion

Overview:
- Decryption-side counterpart of the AES-128 forward key schedule. It takes the cipher key and emits the eleven round keys in reverse order (round 10 down to round 0), one per valid/ready handshake. The inverse cipher consumes them in this order.
- Internal flow: forward-walk 10 rounds to reach round key 10, then step the schedule backwards one round per accepted key.
- Holds a single 128-bit working key register; the 11-entry key table is not stored.
- Reuses the codebase's existing subword and rotate primitives.

Parameters:
- K, 128, key length in bits; only 128 is supported. Any other value is a configuration error and must fail elaboration.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  request a new schedule; sampled only in IDLE
- key  input  128  cipher key; sampled on the clk edge that accepts start; w0 = key[127:96]
- busy  output  1  high in FWD and REV
- roundKey  output  128  current round key (registered)
- round  output  4  round index of roundKey, 0..10
- rkValid  output  1  roundKey/round valid for the consumer
- rkReady  input  1  consumer accepts roundKey this cycle
- done  output  1  one-cycle pulse after round 0 is accepted

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - roundKey=0, round=0, rkValid=0, busy=0, done=0.
  - Internal Rcon state cleared.
  - Reset mid-FWD or mid-REV aborts immediately; no further keys are emitted.
- States: IDLE, FWD, REV.
- IDLE:
  - On a clk edge with start=1: roundKey<=key, round<=0, state<=FWD.
  - done is low in IDLE except for the single pulse cycle defined below.
- FWD:
  - Each edge: roundKey<=forward step of roundKey using Rcon[round+1], and round<=round+1.
  - When round reaches 10 (10th FWD edge): state<=REV, rkValid<=1.
  - rkValid is therefore first high in the cycle after the 10th edge following the start edge.
- Forward step, words w0..w3:
  - t = SubWord(RotWord(w3)) ^ {Rcon,24'h0}
  - n0 = w0^t, n1 = w1^n0, n2 = w2^n1, n3 = w3^n2
- Reverse step from round i, words w0..w3:
  - p3 = w3^w2, p2 = w2^w1, p1 = w1^w0
  - p0 = w0 ^ SubWord(RotWord(p3)) ^ {Rcon[i],24'h0}
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
  - Table lookup on round, or xtime / inverse-xtime, are both acceptable.
  - Inverse-xtime rule: x[0] ? ((x^8'h1b)>>1)|8'h80 : x>>1.
- REV:
  - rkValid=1 throughout.
  - On an edge with rkReady=1 and round>0: roundKey<=reverse step, round<=round-1.
  - On an edge with rkReady=1 and round=0: rkValid<=0, state<=IDLE, done<=1 for exactly one cycle.
  - If rkReady=0: roundKey and round hold stable (AXI-style; no combinational rkReady→rkValid path).
- Only one SubWord instance is used. Its input is muxed: w3 in FWD, p3 in REV.
- start while busy: ignored; key is not re-sampled.
- start in the done-pulse cycle: accepted normally (state is already IDLE).
- roundKey retains the round-0 key after completion until the next start or reset.
- Throughput:
  - 10 cycles fill.
  - Then 1 key per cycle with rkReady tied high.
  - One schedule every 22 cycles back-to-back: start edge, 10 FWD, 11 REV.

Test Plan:
- FIPS-197 vector, rkReady=1: key=2b7e151628aed2a6abf7158809cf4f3c, start pulse.
  - rkValid rises 10 cycles after the start edge.
  - round=10, roundKey=d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Next cycle: round=9, roundKey=ac7766f319fadc2128d12941575c006e.
  - Round 1: a0fafe1788542cb123a339392a6c7605.
  - Round 0: the original key.
  - done pulses once; busy then 0.
- Backpressure: rkReady randomly low ~50%.
  - roundKey/round never change while rkValid=1 and rkReady=0.
  - All 11 keys are received exactly once, in order 10..0.
- Start while busy: second start with key=000102030405060708090a0b0c0d0e0f during FWD.
  - Ignored; output sequence still matches the 2b7e… schedule.
- Back-to-back: start asserted in the done cycle with key=000102030405060708090a0b0c0d0e0f.
  - Round-10 key = 13111d7fe3944a17f307a78b4d2b30c5.
- Async reset mid-REV: drive reset=0 at round=5, asynchronously to clk.
  - rkValid, busy, roundKey, round go to 0 without a clk edge.
  - After release, a new start produces a correct full schedule.
- Random keys (≥1000): emitted sequence equals the reversed output of the forward keyexpansion model.
